// File: rtl/misc_v_pkg.sv
// Shared MISC-V core types: word width, MEM-stage FSM encoding, EX/MEM register layout.
// Also holds the default access timeout used when MEM_STAGE_TIMEOUT_EN is defined.
package misc_v_pkg;

   localparam int WORD_W          = 16;
   localparam int TIMEOUT_DEFAULT = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   typedef struct packed {
      logic              reg_write;
      logic              reg_store;
      logic              mem_write;
      logic              mem_read;
      logic [WORD_W-1:0] pcp2;
      logic [WORD_W-1:0] alu_result;
      logic [WORD_W-1:0] arg3;
      logic [WORD_W-1:0] rd;
   } exmem_t;

endpackage

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: loads when enabled, holds otherwise, clears on synchronous active-low reset.
// One cycle latency; the enable is the only backpressure (driven low while MEM stalls).
module ex_mem_reg
   import misc_v_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   i_en,
   input  exmem_t i_d,
   output exmem_t o_q
);

   exmem_t r_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register plus req/ack data-memory access; stalls upstream while an access waits.
// Non-memops add no latency; optional access timeout and sticky fault under MEM_STAGE_TIMEOUT_EN.
module mem_stage
   import misc_v_pkg::*;
#(
   parameter int DATA_W         = WORD_W,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              IRegWrite,
   input  logic              IRegStore,
   input  logic              IMemWrite,
   input  logic              IMemRead,
   input  logic [DATA_W-1:0] IPCP2,
   input  logic [DATA_W-1:0] IALUResult,
   input  logic [DATA_W-1:0] I3rdArg,
   input  logic [DATA_W-1:0] IRd,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              stall_o,
   output logic [DATA_W-1:0] ALUResultMEM,
   output logic              ORegWrite,
   output logic              ORegStore,
   output logic [DATA_W-1:0] OALUResult,
   output logic [DATA_W-1:0] OLoadData,
   output logic [DATA_W-1:0] OPCP2,
   output logic [DATA_W-1:0] ORd
`ifdef MEM_STAGE_TIMEOUT_EN
   ,
   output logic              mem_fault
`endif
);

   state_t r_state;
   state_t w_state_nxt;
   exmem_t w_d;
   exmem_t w_r;
   logic   w_busy;
   logic   w_done;
   logic   w_timeout;
   logic   w_in_memop;

   assign w_d = '{reg_write:  IRegWrite,
                  reg_store:  IRegStore,
                  mem_write:  IMemWrite,
                  mem_read:   IMemRead,
                  pcp2:       IPCP2,
                  alu_result: IALUResult,
                  arg3:       I3rdArg,
                  rd:         IRd};

   ex_mem_reg u_ex_mem_reg (
      .clk   (clk),
      .reset (reset),
      .i_en  (~stall_o),
      .i_d   (w_d),
      .o_q   (w_r)
   );

   assign w_busy     = (r_state == ST_BUSY);
   assign w_in_memop = IMemRead | IMemWrite;
   assign w_done     = w_busy & (mem_ack | w_timeout);
   assign stall_o    = w_busy & ~w_done;

`ifdef MEM_STAGE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_fault;

   assign w_timeout = w_busy & ~mem_ack & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign mem_fault = r_fault;

   // Count restarts whenever a fresh access begins, including back-to-back ones.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_fault <= 1'b0;
      end else begin
         if ((w_state_nxt == ST_BUSY) && (!w_busy || w_done)) begin
            r_cnt <= '0;
         end else if (w_busy && !mem_ack) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_timeout) begin
            r_fault <= 1'b1;
         end
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_in_memop) w_state_nxt = ST_BUSY;
         ST_BUSY: if (w_done)     w_state_nxt = w_in_memop ? ST_BUSY : ST_IDLE;
         default:                 w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A read+write op drives mem_we high, so it behaves as a store.
   assign mem_req   = w_busy;
   assign mem_we    = w_busy & w_r.mem_write;
   assign mem_addr  = w_busy ? w_r.alu_result : '0;
   assign mem_wdata = w_busy ? w_r.arg3       : '0;

   assign ALUResultMEM = w_r.alu_result;
   assign OALUResult   = w_r.alu_result;
   assign OPCP2        = w_r.pcp2;
   assign ORd          = w_r.rd;
   assign OLoadData    = (w_busy & ~w_timeout) ? mem_rdata : '0;
   assign ORegWrite    = w_r.reg_write & ~stall_o;
   assign ORegStore    = w_r.reg_store & ~stall_o;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a writeback scoreboard; covers the timeout path when MEM_STAGE_TIMEOUT_EN is defined.
module tb_mem_stage;

   logic        clk;
   logic        reset;
   logic        IRegWrite, IRegStore, IMemWrite, IMemRead;
   logic [15:0] IPCP2, IALUResult, I3rdArg, IRd;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic        mem_req, mem_we, stall_o;
   logic [15:0] mem_addr, mem_wdata, ALUResultMEM;
   logic        ORegWrite, ORegStore;
   logic [15:0] OALUResult, OLoadData, OPCP2, ORd;
`ifdef MEM_STAGE_TIMEOUT_EN
   logic        mem_fault;
`endif

   int n_cmp = 0;
   int n_mis = 0;

   typedef struct {
      logic        rw;
      logic        rs;
      logic [15:0] alu;
      logic [15:0] ld;
      logic [15:0] pc;
      logic [15:0] rd;
   } exp_t;

   exp_t sb[$];

   mem_stage #(.DATA_W(16), .TIMEOUT_CYCLES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .IRegWrite    (IRegWrite),
      .IRegStore    (IRegStore),
      .IMemWrite    (IMemWrite),
      .IMemRead     (IMemRead),
      .IPCP2        (IPCP2),
      .IALUResult   (IALUResult),
      .I3rdArg      (I3rdArg),
      .IRd          (IRd),
      .mem_rdata    (mem_rdata),
      .mem_ack      (mem_ack),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .stall_o      (stall_o),
      .ALUResultMEM (ALUResultMEM),
      .ORegWrite    (ORegWrite),
      .ORegStore    (ORegStore),
      .OALUResult   (OALUResult),
      .OLoadData    (OLoadData),
      .OPCP2        (OPCP2),
      .ORd          (ORd)
`ifdef MEM_STAGE_TIMEOUT_EN
      ,
      .mem_fault    (mem_fault)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic op(input logic rw, input logic rs, input logic mw, input logic mr,
                     input logic [15:0] pc, input logic [15:0] alu,
                     input logic [15:0] a3, input logic [15:0] rd);
      IRegWrite  = rw;
      IRegStore  = rs;
      IMemWrite  = mw;
      IMemRead   = mr;
      IPCP2      = pc;
      IALUResult = alu;
      I3rdArg    = a3;
      IRd        = rd;
   endtask

   task automatic nop();
      op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
   endtask

   task automatic push(input logic rw, input logic rs, input logic [15:0] alu,
                       input logic [15:0] ld, input logic [15:0] pc, input logic [15:0] rd);
      exp_t e;
      e.rw = rw; e.rs = rs; e.alu = alu; e.ld = ld; e.pc = pc; e.rd = rd;
      sb.push_back(e);
   endtask

   // Writeback monitor: every non-bubble output must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (reset === 1'b1 && (ORegWrite === 1'b1 || ORegStore === 1'b1)) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_mis++;
            $error("FAIL sb_unexpected: observed alu %h rd %h expected no writeback", OALUResult, ORd);
         end else begin
            e = sb.pop_front();
            chk("wb_regwrite", {15'b0, ORegWrite}, {15'b0, e.rw});
            chk("wb_regstore", {15'b0, ORegStore}, {15'b0, e.rs});
            chk("wb_alu",      OALUResult, e.alu);
            chk("wb_load",     OLoadData,  e.ld);
            chk("wb_pcp2",     OPCP2,      e.pc);
            chk("wb_rd",       ORd,        e.rd);
         end
      end
   end

   initial begin
      reset     = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = 16'h0;
      nop();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req",   {15'b0, mem_req},   16'h0);
      chk("rst_stall", {15'b0, stall_o},   16'h0);
      chk("rst_rw",    {15'b0, ORegWrite}, 16'h0);
      chk("rst_alu",   OALUResult,         16'h0);
      chk("rst_addr",  mem_addr,           16'h0);
      @(negedge clk) reset = 1'b1;

      // ALU op through a pure register stage
      @(negedge clk) op(1, 0, 0, 0, 16'h0102, 16'h1234, 16'h0, 16'h0003);
      push(1, 0, 16'h1234, 16'h0, 16'h0102, 16'h0003);
      @(negedge clk) nop();
      #1;
      chk("alu_rw",    {15'b0, ORegWrite}, 16'h1);
      chk("alu_res",   OALUResult,         16'h1234);
      chk("alu_fwd",   ALUResultMEM,       16'h1234);
      chk("alu_req",   {15'b0, mem_req},   16'h0);
      chk("alu_stall", {15'b0, stall_o},   16'h0);

      // Zero-wait load
      @(negedge clk) op(1, 0, 0, 1, 16'h0202, 16'h0040, 16'h0, 16'h0005);
      push(1, 0, 16'h0040, 16'hBEEF, 16'h0202, 16'h0005);
      @(negedge clk) begin nop(); mem_ack = 1'b1; mem_rdata = 16'hBEEF; end
      #1;
      chk("ld0_req",   {15'b0, mem_req}, 16'h1);
      chk("ld0_we",    {15'b0, mem_we},  16'h0);
      chk("ld0_addr",  mem_addr,         16'h0040);
      chk("ld0_data",  OLoadData,        16'hBEEF);
      chk("ld0_stall", {15'b0, stall_o}, 16'h0);
      @(negedge clk) begin mem_ack = 1'b0; mem_rdata = 16'h0; end
      #1;
      chk("ld0_idle_req",   {15'b0, mem_req}, 16'h0);
      chk("ld0_idle_stall", {15'b0, stall_o}, 16'h0);

      // Store with three wait cycles; the following ALU op waits at the inputs
      @(negedge clk) op(0, 1, 1, 0, 16'h0302, 16'h0010, 16'h00A5, 16'h0);
      push(0, 1, 16'h0010, 16'h0, 16'h0302, 16'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk) op(1, 0, 0, 0, 16'h0402, 16'h7777, 16'h0, 16'h0009);
         #1;
         chk("st_stall", {15'b0, stall_o},   16'h1);
         chk("st_req",   {15'b0, mem_req},   16'h1);
         chk("st_we",    {15'b0, mem_we},    16'h1);
         chk("st_wdata", mem_wdata,          16'h00A5);
         chk("st_addr",  mem_addr,           16'h0010);
         chk("st_rw",    {15'b0, ORegWrite}, 16'h0);
         chk("st_rs",    {15'b0, ORegStore}, 16'h0);
      end
      @(negedge clk) mem_ack = 1'b1;
      push(1, 0, 16'h7777, 16'h0, 16'h0402, 16'h0009);
      #1;
      chk("st_ack_stall", {15'b0, stall_o},   16'h0);
      chk("st_ack_rs",    {15'b0, ORegStore}, 16'h1);
      @(negedge clk) begin mem_ack = 1'b0; nop(); end
      #1;
      chk("st_next_alu", OALUResult,       16'h7777);
      chk("st_next_rd",  ORd,              16'h0009);
      chk("st_next_req", {15'b0, mem_req}, 16'h0);

      // Back-to-back loads, one wait each
      @(negedge clk) op(1, 0, 0, 1, 16'h0502, 16'h0100, 16'h0, 16'h0001);
      push(1, 0, 16'h0100, 16'h1111, 16'h0502, 16'h0001);
      @(negedge clk) op(1, 0, 0, 1, 16'h0602, 16'h0102, 16'h0, 16'h0002);
      #1;
      chk("b2b_a_stall", {15'b0, stall_o}, 16'h1);
      @(negedge clk) begin mem_ack = 1'b1; mem_rdata = 16'h1111; end
      push(1, 0, 16'h0102, 16'h2222, 16'h0602, 16'h0002);
      #1;
      chk("b2b_a_ack_stall", {15'b0, stall_o}, 16'h0);
      chk("b2b_a_data",      OLoadData,        16'h1111);
      @(negedge clk) begin nop(); mem_ack = 1'b0; mem_rdata = 16'h0; end
      #1;
      chk("b2b_b_stall", {15'b0, stall_o}, 16'h1);
      chk("b2b_b_req",   {15'b0, mem_req}, 16'h1);
      chk("b2b_b_addr",  mem_addr,         16'h0102);
      @(negedge clk) begin mem_ack = 1'b1; mem_rdata = 16'h2222; end
      #1;
      chk("b2b_b_ack_stall", {15'b0, stall_o}, 16'h0);
      chk("b2b_b_data",      OLoadData,        16'h2222);
      @(negedge clk) begin mem_ack = 1'b0; mem_rdata = 16'h0; end
      #1;
      chk("b2b_end_req", {15'b0, mem_req}, 16'h0);

      // Reset in the second BUSY cycle of an unacked load; late ack ignored
      @(negedge clk) op(1, 0, 0, 1, 16'h0702, 16'h0200, 16'h0, 16'h0004);
      @(negedge clk) nop();
      #1;
      chk("rb_req1", {15'b0, mem_req}, 16'h1);
      @(negedge clk) reset = 1'b0;
      #1;
      chk("rb_stall2", {15'b0, stall_o}, 16'h1);
      @(negedge clk) begin reset = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD; end
      #1;
      chk("rb_req",   {15'b0, mem_req},   16'h0);
      chk("rb_stall", {15'b0, stall_o},   16'h0);
      chk("rb_alu",   OALUResult,         16'h0);
      chk("rb_pc",    OPCP2,              16'h0);
      chk("rb_rd",    ORd,                16'h0);
      chk("rb_rw",    {15'b0, ORegWrite}, 16'h0);
      chk("rb_ld",    OLoadData,          16'h0);
      @(negedge clk) begin mem_ack = 1'b0; mem_rdata = 16'h0; end
      #1;
      chk("rb_late_req", {15'b0, mem_req}, 16'h0);
      chk("rb_late_alu", OALUResult,       16'h0);

`ifdef MEM_STAGE_TIMEOUT_EN
      // Never-acked load is force-completed after three stall cycles
      @(negedge clk) op(1, 0, 0, 1, 16'h0802, 16'h0300, 16'h0, 16'h0006);
      push(1, 0, 16'h0300, 16'h0, 16'h0802, 16'h0006);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk) begin nop(); mem_rdata = 16'hFFFF; end
         #1;
         chk("to_stall", {15'b0, stall_o},   16'h1);
         chk("to_fault", {15'b0, mem_fault}, 16'h0);
      end
      @(negedge clk);
      #1;
      chk("to_done_stall", {15'b0, stall_o},   16'h0);
      chk("to_done_ld",    OLoadData,          16'h0);
      chk("to_done_rw",    {15'b0, ORegWrite}, 16'h1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk) mem_rdata = 16'h0;
         #1;
         chk("to_fault_sticky", {15'b0, mem_fault}, 16'h1);
         chk("to_idle_req",     {15'b0, mem_req},   16'h0);
      end
      @(negedge clk) reset = 1'b0;
      @(negedge clk) reset = 1'b1;
      #1;
      chk("to_fault_clr", {15'b0, mem_fault}, 16'h0);
`endif

      @(negedge clk);
      #3;
      chk("sb_drained", 16'(sb.size()), 16'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
